// File: rtl/sha256_pkg.sv
// Shared constants and FSM encoding for the SHA-256 block controller.
package sha256_pkg;

    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 512;
    localparam int DIG_W   = 256;

    localparam logic [DIG_W-1:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_START = 3'd1;
    localparam state_t S_SCHED = 3'd2;
    localparam state_t S_WAIT  = 3'd3;
    localparam state_t S_UPD   = 3'd4;
    localparam state_t S_OUT   = 3'd5;

endpackage

// File: rtl/sha256_h_update.sv
// Eight-lane mod-2^32 feed-forward add of chaining value and final a..h.
module sha256_h_update
    import sha256_pkg::*;
(
    input  logic [DIG_W-1:0] h_i,
    input  logic [DIG_W-1:0] s_i,
    output logic [DIG_W-1:0] h_o
);

    always_comb begin
        h_o = '0;
        for (int i = 0; i < 8; i++) begin
            h_o[i*WORD_W +: WORD_W] = h_i[i*WORD_W +: WORD_W]
                                    + s_i[i*WORD_W +: WORD_W];
        end
    end

endmodule

// File: rtl/sha256_block_ctrl.sv
// Block sequencer between padding front-end and scheduler/compression pair.
// Define SHA256_BLOCK_CTRL_PERF_EN to add the perf_cycles output.
module sha256_block_ctrl
    import sha256_pkg::*;
#(
    parameter int GROUPS_PER_BLOCK = 8,
    parameter int TIMEOUT_CYCLES   = 64,
    parameter int CNT_W            = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic               blk_last,
    input  logic [BLOCK_W-1:0] blk_data,
    output logic               sch_input_valid,
    output logic [BLOCK_W-1:0] sch_block,
    input  logic               sch_ready,
    input  logic               sch_valid,
    input  logic [DIG_W-1:0]   sch_w,
    output logic               cmp_init,
    output logic [DIG_W-1:0]   cmp_h,
    output logic               cmp_w_valid,
    output logic [DIG_W-1:0]   cmp_w,
    input  logic               cmp_done,
    input  logic [DIG_W-1:0]   cmp_state,
    output logic               digest_valid,
    output logic [DIG_W-1:0]   digest,
    input  logic               digest_ready,
    output logic               busy,
    output logic               err
`ifdef SHA256_BLOCK_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]   perf_cycles
`endif
);

    localparam logic [2:0]       GRP_LAST = 3'(GROUPS_PER_BLOCK - 1);
    localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT_CYCLES);

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic [2:0]         grp_q, grp_d;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic [DIG_W-1:0]   h_q, h_d;
    logic [DIG_W-1:0]   st_q, st_d;
    logic [DIG_W-1:0]   w_q, w_d;
    logic               wv_q, wv_d;
    logic               err_q, err_d;
    logic [DIG_W-1:0]   h_sum;
    logic               in_run;
    logic               tmo_hit;

    sha256_h_update u_h_update (
        .h_i (h_q),
        .s_i (st_q),
        .h_o (h_sum)
    );

    assign in_run = (state_q == S_START) || (state_q == S_SCHED)
                 || (state_q == S_WAIT);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        blk_d   = blk_q;
        grp_d   = grp_q;
        tmo_d   = tmo_q;
        h_d     = h_q;
        st_d    = st_q;
        w_d     = w_q;
        wv_d    = 1'b0;
        err_d   = err_q;
        tmo_hit = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (blk_valid && blk_ready) begin
                    blk_d   = blk_data;
                    last_d  = blk_last;
                    state_d = S_START;
                end
            end
            S_START: begin
                grp_d   = '0;
                state_d = S_SCHED;
            end
            S_SCHED: begin
                if (sch_valid) begin
                    w_d   = sch_w;
                    wv_d  = 1'b1;
                    grp_d = grp_q + 3'd1;
                    if (grp_q == GRP_LAST) begin
                        state_d = S_WAIT;
                    end
                end
                // early completion is a protocol violation, not a result
                if (cmp_done) begin
                    err_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (cmp_done) begin
                    st_d    = cmp_state;
                    state_d = S_UPD;
                end
            end
            S_UPD: begin
                h_d     = h_sum;
                state_d = last_q ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                if (digest_ready) begin
                    h_d     = SHA256_IV;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (sch_valid && (state_q != S_SCHED)) begin
            err_d = 1'b1;
        end

        if (in_run) begin
            if (sch_valid || cmp_done) begin
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_d == TMO_MAX) begin
                    tmo_hit = 1'b1;
                end
            end
        end else begin
            tmo_d = '0;
        end

        // a stalled partner abandons the whole message
        if (tmo_hit) begin
            err_d   = 1'b1;
            h_d     = SHA256_IV;
            state_d = S_IDLE;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= 1'b0;
            blk_q   <= '0;
            grp_q   <= '0;
            tmo_q   <= '0;
            h_q     <= SHA256_IV;
            st_q    <= '0;
            w_q     <= '0;
            wv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            blk_q   <= blk_d;
            grp_q   <= grp_d;
            tmo_q   <= tmo_d;
            h_q     <= h_d;
            st_q    <= st_d;
            w_q     <= w_d;
            wv_q    <= wv_d;
            err_q   <= err_d;
        end
    end

    assign blk_ready       = (state_q == S_IDLE) && sch_ready;
    assign sch_input_valid = (state_q == S_START);
    assign cmp_init        = (state_q == S_START);
    assign sch_block       = blk_q;
    assign cmp_h           = h_q;
    assign cmp_w_valid     = wv_q;
    assign cmp_w           = w_q;
    assign digest_valid    = (state_q == S_OUT);
    assign digest          = digest_valid ? h_q : '0;
    assign busy            = (state_q != S_IDLE);
    assign err             = err_q;

`ifdef SHA256_BLOCK_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_q, perf_d;
    logic             run_q, run_d;

    always_comb begin
        perf_d = perf_q;
        run_d  = run_q;
        if ((state_q == S_IDLE) && blk_valid && blk_ready && !run_q) begin
            run_d  = 1'b1;
            perf_d = '0;
        end else if (run_q && (state_q != S_OUT) && (perf_q != '1)) begin
            perf_d = perf_q + 1'b1;
        end
        if (tmo_hit || ((state_q == S_OUT) && digest_ready)) begin
            run_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
            run_q  <= 1'b0;
        end else begin
            perf_q <= perf_d;
            run_q  <= run_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Randomized bench for sha256_block_ctrl with scheduler/compression models.
module tb_sha256_block_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic         blk_last = 1'b0;
    logic [511:0] blk_data = '0;
    logic         sch_input_valid;
    logic [511:0] sch_block;
    logic         sch_ready = 1'b0;
    logic         sch_valid = 1'b0;
    logic [255:0] sch_w = '0;
    logic         cmp_init;
    logic [255:0] cmp_h;
    logic         cmp_w_valid;
    logic [255:0] cmp_w;
    logic         cmp_done = 1'b0;
    logic [255:0] cmp_state = '0;
    logic         digest_valid;
    logic [255:0] digest;
    logic         digest_ready = 1'b0;
    logic         busy;
    logic         err;
`ifdef SHA256_BLOCK_CTRL_PERF_EN
    logic [15:0]  perf_cycles;
`endif

    always #5 clk = ~clk;

    sha256_block_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .blk_valid       (blk_valid),
        .blk_ready       (blk_ready),
        .blk_last        (blk_last),
        .blk_data        (blk_data),
        .sch_input_valid (sch_input_valid),
        .sch_block       (sch_block),
        .sch_ready       (sch_ready),
        .sch_valid       (sch_valid),
        .sch_w           (sch_w),
        .cmp_init        (cmp_init),
        .cmp_h           (cmp_h),
        .cmp_w_valid     (cmp_w_valid),
        .cmp_w           (cmp_w),
        .cmp_done        (cmp_done),
        .cmp_state       (cmp_state),
        .digest_valid    (digest_valid),
        .digest          (digest),
        .digest_ready    (digest_ready),
        .busy            (busy),
        .err             (err)
`ifdef SHA256_BLOCK_CTRL_PERF_EN
        ,
        .perf_cycles     (perf_cycles)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag,
                         input logic [511:0] got,
                         input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] ivw [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    logic [31:0] hm [8];

    function automatic logic [255:0] pack_iv();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = ivw[i];
        return r;
    endfunction

    function automatic logic [255:0] hm_packed();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hm[i];
        return r;
    endfunction

    task automatic hm_reset();
        for (int i = 0; i < 8; i++) hm[i] = ivw[i];
    endtask

    task automatic hm_apply(input logic [255:0] s);
        for (int i = 0; i < 8; i++) hm[i] = hm[i] + s[255-32*i -: 32];
    endtask

    // scheduler model
    int           grp_left = 0;
    int           grp_consumed = 0;
    int           starts = 0;
    logic         no_sch = 1'b0;
    logic         kill_sch = 1'b0;
    logic [255:0] wq [$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                grp_left  = 0;
                sch_valid = 1'b0;
                sch_ready = 1'b0;
                wq.delete();
            end else begin
                if (sch_valid) begin
                    grp_left--;
                    grp_consumed++;
                end
                sch_valid = 1'b0;
                if (sch_input_valid) begin
                    starts++;
                    grp_left  = 8;
                    sch_ready = 1'b0;
                end else if (kill_sch) begin
                    grp_left  = 0;
                    sch_ready = 1'b1;
                end else if (grp_left > 0) begin
                    if (!no_sch && $urandom_range(3) != 0) begin
                        sch_valid = 1'b1;
                        for (int i = 0; i < 8; i++) sch_w[i*32 +: 32] = $urandom();
                        wq.push_back(sch_w);
                    end
                end else begin
                    sch_ready = 1'b1;
                end
            end
        end
    end

    // compression model
    int           wcnt = 0;
    int           cdelay = -1;
    int           wvalids = 0;
    logic [255:0] cur_state = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wcnt     = 0;
                cdelay   = -1;
                cmp_done = 1'b0;
            end else begin
                cmp_done = 1'b0;
                if (cmp_init) wcnt = 0;
                if (cmp_w_valid) begin
                    wvalids++;
                    if (wq.size() == 0) check("cmp_w_extra", cmp_w_valid, 0);
                    else check("cmp_w", cmp_w, wq.pop_front());
                    wcnt++;
                    if (wcnt == 8) cdelay = $urandom_range(3);
                end
                if (cdelay == 0) begin
                    cmp_done  = 1'b1;
                    cmp_state = cur_state;
                    cdelay    = -1;
                end else if (cdelay > 0) begin
                    cdelay--;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic accept(input logic [511:0] d, input logic l);
        int n = 0;
        while (!blk_ready && n < 200) begin
            tick();
            n++;
        end
        check("blk_ready_wait", n < 200, 1);
        blk_valid = 1'b1;
        blk_data  = d;
        blk_last  = l;
        tick();
        blk_valid = 1'b0;
        check("sch_block", sch_block, d);
        check("busy_start", busy, 1);
    endtask

    task automatic send_block(input logic [511:0] d, input logic l,
                              input logic [255:0] s);
        int n = 0;
        int st0 = starts;
        int wv0 = wvalids;
        logic saw_dv = 1'b0;
        cur_state = s;
        accept(d, l);
        hm_apply(s);
        if (l) begin
            while (!digest_valid && n < 300) begin
                tick();
                n++;
            end
            check("digest_wait", n < 300, 1);
        end else begin
            while (busy && n < 300) begin
                if (digest_valid) saw_dv = 1'b1;
                tick();
                n++;
            end
            check("idle_wait", n < 300, 1);
            check("no_early_digest", saw_dv, 0);
            check("cmp_h_chain", cmp_h, hm_packed());
        end
        check("start_pulses", starts - st0, 1);
        check("w_valid_cycles", wvalids - wv0, 8);
    endtask

    task automatic finish_msg(input int hold);
        check("digest", digest, hm_packed());
        for (int i = 0; i < hold; i++) begin
            tick();
            check("digest_hold", digest, hm_packed());
            check("dv_hold", digest_valid, 1);
            check("blk_ready_out", blk_ready, 0);
        end
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;
        hm_reset();
        check("dv_drop", digest_valid, 0);
        check("cmp_h_iv", cmp_h, hm_packed());
        check("busy_done", busy, 0);
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    function automatic logic [255:0] rand_st();
        logic [255:0] s;
        for (int i = 0; i < 8; i++) s[i*32 +: 32] = $urandom();
        return s;
    endfunction

    logic [511:0] abc_blk;
    logic [255:0] abc_st;
    logic [255:0] abc_dig;
    logic [255:0] ones_st;

    initial begin
        abc_blk = {32'h61626380, 448'h0, 32'h00000018};
        abc_st  = {32'h506e3058, 32'hd39a2165, 32'h04d24d6c, 32'hb85e2ce9,
                   32'h5ef50f24, 32'hfb121210, 32'h948d25b6, 32'h961f4894};
        abc_dig = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                   32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
        ones_st = '1;
        hm_reset();

        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_dv", digest_valid, 0);
        check("rst_digest", digest, 0);
        check("rst_cmp_h", cmp_h, pack_iv());
        check("rst_blk_ready", blk_ready, 0);
        check("rst_wv", cmp_w_valid, 0);
        check("rst_start", sch_input_valid, 0);
        rst_n = 1'b1;
        tick();

        send_block(abc_blk, 1'b1, abc_st);
        check("abc_digest", digest, abc_dig);
        finish_msg(0);

        send_block(rand_blk(), 1'b1, ones_st);
        finish_msg(1);

        send_block(rand_blk(), 1'b0, 256'h0);
        check("two_blk_h_iv", cmp_h, pack_iv());
        send_block(rand_blk(), 1'b1, {8{32'h00000001}});
        finish_msg(5);

        for (int m = 0; m < 6; m++) begin
            int nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                send_block(rand_blk(), b == nb - 1, rand_st());
            end
            finish_msg($urandom_range(0, 3));
        end
        check("no_err_yet", err, 0);

        begin
            int k = 0;
            no_sch = 1'b1;
            accept(rand_blk(), 1'b1);
            repeat (30) begin
                tick();
                k++;
            end
            check("tmo_early_err", err, 0);
            check("tmo_early_busy", busy, 1);
            while (!err && k < 120) begin
                tick();
                k++;
            end
            check("tmo_cycles", k, 64);
            check("tmo_err", err, 1);
            check("tmo_idle", busy, 0);
            check("tmo_cmp_h", cmp_h, pack_iv());
            check("tmo_blk_ready0", blk_ready, 0);
            kill_sch = 1'b1;
            tick();
            check("tmo_blk_ready1", blk_ready, 1);
            kill_sch = 1'b0;
            no_sch   = 1'b0;
            hm_reset();
        end

        begin
            int g0 = grp_consumed;
            int n = 0;
            cur_state = abc_st;
            accept(abc_blk, 1'b1);
            while (grp_consumed - g0 < 3 && n < 100) begin
                tick();
                n++;
            end
            check("mid_grp_wait", n < 100, 1);
            rst_n = 1'b0;
            #1;
            check("mid_busy", busy, 0);
            check("mid_err", err, 0);
            check("mid_cmp_h", cmp_h, pack_iv());
            check("mid_dv", digest_valid, 0);
            check("mid_wv", cmp_w_valid, 0);
            check("mid_sch_block", sch_block, 0);
            tick();
            check("mid_blk_ready", blk_ready, 0);
            rst_n = 1'b1;
            tick();
            hm_reset();
        end

        send_block(abc_blk, 1'b1, abc_st);
        check("abc2_digest", digest, abc_dig);
        finish_msg(2);
        check("final_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sha256_block_ctrl.md
Name: sha256_block_ctrl

Overview:
Sequences one SHA-256 message (one or more 512-bit padded blocks) through the message scheduler and an external 64-round compression core. Accepts blocks over a valid/ready handshake and starts the scheduler per block. Forwards the scheduler's eight 256-bit word groups to the compression core, performs the per-block H feed-forward addition, and presents the final digest. Sits between the host/padding front-end and the sha256_message_scheduler + compression pair.

Parameters:
GROUPS_PER_BLOCK, 8, 256-bit W groups per block (8 x 8 words = W0..W63)
TIMEOUT_CYCLES, 64, max idle cycles waiting on scheduler/compression before error
CNT_W, 16, width of timeout/perf counters

Ports:
clk  in  1  system clock
rst_n  in  1  reset
blk_valid  in  1  upstream block available
blk_ready  out  1  controller accepts block this cycle
blk_last  in  1  qualifies blk_data as final block of message
blk_data  in  512  padded message block, word0 in [511:480]
sch_input_valid  out  1  one-cycle start pulse to scheduler
sch_block  out  512  block to scheduler, registered
sch_ready  in  1  scheduler idle
sch_valid  in  1  scheduler W group valid
sch_w  in  256  W group, earliest word in [255:224]
cmp_init  out  1  one-cycle pulse: load working vars a..h from cmp_h
cmp_h  out  256  current chaining value H0..H7, H0 in [255:224]
cmp_w_valid  out  1  W group valid to compression
cmp_w  out  256  registered copy of sch_w
cmp_done  in  1  compression finished 64 rounds
cmp_state  in  256  final a..h, a in [255:224]
digest_valid  out  1  digest available
digest  out  256  H0..H7
digest_ready  in  1  downstream takes digest
busy  out  1  state != IDLE
err  out  1  sticky protocol/timeout error

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-low rst_n. All outputs 0, except blk_ready=0 and cmp_h=IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19). State IDLE, counters 0, err 0.
- States: IDLE -> START -> SCHED -> WAIT_CMP -> UPDATE -> (OUTPUT | IDLE).
- IDLE: blk_ready = sch_ready. On blk_valid&&blk_ready, latch blk_data into sch_block and latch blk_last; go to START.
- START: assert sch_input_valid and cmp_init for exactly one cycle; clear group counter; go to SCHED.
- SCHED: each cycle sch_valid=1, register sch_w into cmp_w and assert cmp_w_valid the next cycle (1-cycle latency); increment 3-bit group counter. After group GROUPS_PER_BLOCK-1 is accepted, go to WAIT_CMP.
- WAIT_CMP: on cmp_done, latch cmp_state and go to UPDATE. cmp_done asserted in SCHED before all groups are forwarded sets err and is ignored.
- UPDATE: single cycle; Hi <= Hi + state_i mod 2^32, eight independent 32-bit adders, carries discarded. If last block, go to OUTPUT; else go to IDLE with H retained for chaining.
- OUTPUT: digest = H, digest_valid=1, held stable until digest_ready. On handshake, H returns to IV and the state goes to IDLE. blk_ready=0 while in OUTPUT.
- Timeout: a counter runs in START/SCHED/WAIT_CMP and clears on any sch_valid or cmp_done. When it reaches TIMEOUT_CYCLES: set err, reset H to IV, return to IDLE.
- sch_valid outside SCHED sets err and is ignored. err clears only on reset.
- Reset mid-operation: immediate abort; H returns to IV; no partial digest is emitted.
- Block latency (scheduler and compression ideal): 1 accept + 1 start + 8 groups + 1 forward + compression + 1 update.

Optional Feature:
SHA256_BLOCK_CTRL_PERF_EN
- When defined: adds output perf_cycles [CNT_W-1:0], counting cycles from the first block accept to digest_valid rise. It is held with the digest and saturates at all-ones.
- When undefined: no port and no counter logic.

Decomposition:
- Package sha256_pkg: SHA256_IV constant (256-bit), WORD_W=32, BLOCK_W=512, state enum typedef.
- Sub-module sha256_h_update: combinational eight-lane mod-2^32 add of H and cmp_state.

Test Plan:
- Single block "abc": blk_data=61626380..0018, blk_last=1; model returns cmp_state=506e3058 d39a2165 04d24d6c b85e2ce9 5ef50f24 fb121210 948d25b6 961f4894 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; exactly one sch_input_valid pulse; 8 cmp_w_valid cycles.
- Wrap-around: single block, cmp_state all ffffffff -> digest = IV-1 per word (6a09e666 bb67ae84 ... 5be0cd18).
- Two-block message: first blk_last=0 with cmp_state=0 -> cmp_h stays IV for block 2; second block cmp_state=00000001 per word -> digest = IV+1 per word; no digest_valid after block 1.
- Backpressure: hold digest_ready=0 for 5 cycles -> digest and digest_valid stable, blk_ready=0; IV is restored after the handshake.
- Timeout: scheduler model never asserts sch_valid -> err=1 after 64 cycles, state IDLE, blk_ready follows sch_ready.
- Reset mid-SCHED after 3 groups -> all outputs at reset values, cmp_h=IV; a subsequent "abc" run yields the correct digest.
